// File: rtl/lsh_seq_a32.sv
// ---------------------------------------------------------------------------
// lsh_seq_a32 -- sequential 32-bit logical left shifter
//
// Computes C = A << B[4:0] by shifting one bit position per clock. It uses a
// start/busy/done handshake so a controller can issue a shift and wait for
// it to finish. It also reports the last bit shifted out of bit 31 on co.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   operation request, only honoured in IDLE
//   A      in  32   operand, captured on the accepting edge
//   B      in  32   shift amount, only B[4:0] is used
//   C      out 32   result, held until the next completion
//   co     out  1   last bit shifted out (A[32-n] for n != 0, else 0)
//   busy   out  1   high in SHIFT and DONE
//   done   out  1   one-cycle pulse; C and co are valid in that cycle
//
// Latency from the accepting edge to done is n+1 cycles for every n = B[4:0].
// ---------------------------------------------------------------------------
module lsh_seq_a32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] C,
    output logic        co,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] sreg_reg, sreg_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic        lastout_reg, lastout_next;
    logic [31:0] c_reg, c_next;
    logic        co_reg, co_next;

    logic [31:0] sreg_shl;
    logic [4:0]  amt;
    logic        unused_b_hi;

    // Only the low five bits of B form the shift amount; the rest is
    // deliberately ignored.
    assign amt         = B[4:0];
    assign unused_b_hi = ^B[31:5];

    // One-position left shift of the working register with zero fill.
    assign sreg_shl[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_shl
            assign sreg_shl[gi] = sreg_reg[gi-1];
        end
    endgenerate

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_reg    <= 32'd0;
            cnt_reg     <= 5'd0;
            lastout_reg <= 1'b0;
            c_reg       <= 32'd0;
            co_reg      <= 1'b0;
        end else begin
            sreg_reg    <= sreg_next;
            cnt_reg     <= cnt_next;
            lastout_reg <= lastout_next;
            c_reg       <= c_next;
            co_reg      <= co_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state and datapath update logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        sreg_next    = sreg_reg;
        cnt_next     = cnt_reg;
        lastout_next = lastout_reg;
        c_next       = c_reg;
        co_next      = co_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    sreg_next    = A;
                    cnt_next     = amt;
                    lastout_next = 1'b0;
                    if (amt == 5'd0) begin
                        // A zero shift publishes A directly. It still
                        // passes through DONE, so latency stays n+1.
                        c_next     = A;
                        co_next    = 1'b0;
                        state_next = DONE;
                    end else begin
                        state_next = SHIFT;
                    end
                end
            end

            SHIFT: begin
                lastout_next = sreg_reg[31];
                sreg_next    = sreg_shl;
                cnt_next     = cnt_reg - 5'd1;
                // Publish on the final shift edge so that C and co are
                // valid together with done. The <= test also terminates
                // cleanly if cnt were ever 0 here, which is unreachable.
                if (cnt_reg <= 5'd1) begin
                    c_next     = sreg_shl;
                    co_next    = lastout_next;
                    state_next = DONE;
                end
            end

            DONE: begin
                // start is not queued; the caller re-asserts it in IDLE.
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Handshake outputs decode registered state only.
    assign busy = (state_reg != IDLE);
    assign done = (state_reg == DONE);
    assign C    = c_reg;
    assign co   = co_reg;

endmodule

// File: doc/lsh_seq_a32.md
# lsh_seq_a32

Sequential 32-bit logical left shifter, the left-direction counterpart of the ALU's right-shift unit. It shares the same A/B/C operand convention and produces the same result a combinational `A << B[4:0]` would. It shifts one bit position per clock under a start/busy/done handshake, so the ALU controller can issue a shift and wait for completion. It also reports the last bit shifted out.

## Interface
- No parameters; the datapath is fixed at 32 bits and the shift amount at 5 bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- A  input  32  operand to shift; sampled on the accepted start edge.
- B  input  32  shift amount; only B[4:0] is used and B[31:5] is ignored; sampled on the accepted start edge.
- C  output  32  result register; holds the last completed result until the next completion.
- co  output  1  last bit shifted out (A[32-n] for n=B[4:0]≠0, else 0); updated together with C.
- busy  output  1  high from the cycle after an accepted start through the done cycle inclusive.
- done  output  1  single-cycle pulse; C and co are valid in this cycle.

## Operation
- States are IDLE, SHIFT and DONE.
- Internal registers:
  - sreg[31:0] is the working shift register.
  - cnt[4:0] is the remaining shift count.
  - lastout is the most recent bit shifted out.
- IDLE, start=1:
  - sreg←A, cnt←B[4:0], lastout←0.
  - If B[4:0]=0: C←A, co←0, go to DONE.
  - Otherwise go to SHIFT.
- IDLE, start=0: no change.
- SHIFT, each edge:
  - lastout←sreg[31], sreg←{sreg[30:0],1'b0}, cnt←cnt-1.
  - When cnt=1 on this edge, C←{sreg[30:0],1'b0} and co←sreg[31] on the same edge, and go to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start is ignored in SHIFT and DONE and is not queued. A start in the DONE cycle is dropped; the caller must re-assert it in IDLE.
- A and B may change freely after the accepted start edge without affecting the result.
- Width rules:
  - Bits shifted out of position 31 are discarded except the final one, which goes to co.
  - Zero-fill from the LSB.
  - No sign handling; this is a logical shift.
- Reset (asynchronous, any state, including mid-shift): state←IDLE, C←0, co←0, busy←0, done←0, sreg←0, cnt←0. An operation in progress is abandoned with no partial result published.
- Release of rst_n is synchronous to clk through the normal registers; the first start is accepted on the first edge with rst_n=1.
- busy=1 in SHIFT and DONE, 0 in IDLE. done=1 only in DONE. Both are decoded from registered state, so they have no combinational path from inputs.

## Timing
- Let cycle 0 be the cycle in which start=1 is sampled in IDLE, with the accepting edge at its end, and let n=B[4:0].
- For n≥1: SHIFT occupies cycles 1..n, and DONE (done=1, C/co valid) is cycle n+1.
- For n=0: DONE is cycle 1.
- Latency from start to done is therefore n+1 cycles for every n (1 to 32 cycles). busy is high for max(n,0)+1 cycles, from cycle 1 to cycle n+1.
- Earliest next accepted start is in cycle n+2 (IDLE), so back-to-back throughput is one operation per n+2 cycles.
- C and co change only on the edge that enters DONE, and hold stable otherwise.

## Test plan
- Reset: rst_n=0 asserted asynchronously mid-cycle → C=0, co=0, busy=0, done=0 immediately, without waiting for a clock edge.
- A=0x0000_0001, B=4, start pulse in cycle 0 → busy high in cycles 1–5; done=1 only in cycle 5 with C=0x0000_0010, co=0.
- A=0x8000_0001, B=1 → done in cycle 2 with C=0x0000_0002, co=1.
- A=0xDEAD_BEEF, B=0 → done in cycle 1 with C=0xDEAD_BEEF, co=0.
- Upper bits of B ignored: A=0xF000_000F, B=0x0000_0023 (shift 3) → C=0x8000_0078, co=1, done in cycle 4.
- Busy rejection and reset abort:
  - A=0x0000_0003, B=31; in cycle 10 apply start=1 with A=0xFFFF_FFFF, B=2. The second start is ignored, and done arrives in cycle 32 with C=0x8000_0000, co=1.
  - Separately, start A=0x1, B=10 and drop rst_n in cycle 3 → outputs reset to 0 and no done pulse appears. A new start after release with A=0x1, B=2 yields C=0x4 in cycle 3 relative to that start.
